// File: rtl/pwm_duty_decoder_if.sv
// rtl/pwm_duty_decoder_if.sv - PWM input line and duty measurement results bundle
interface pwm_duty_decoder_if #(
    parameter int CNT_W = 16
);
    logic             pwm_in;
    logic [3:0]       duty_out;
    logic             duty_valid;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             stuck;
    logic             overrun;

    // decoder side: samples the line, drives the results
    modport master (
        input  pwm_in,
        output duty_out, duty_valid, period_out, high_out, stuck, overrun
    );

    // environment side: drives the line, consumes the results
    modport slave (
        output pwm_in,
        input  duty_out, duty_valid, period_out, high_out, stuck, overrun
    );
endinterface

// File: rtl/pwm_duty_decoder.sv
// rtl/pwm_duty_decoder.sv - PWM period/high-time measurement and duty-in-tenths decoder (optional PWM_DEC_GLITCH_FILTER_EN)
module pwm_duty_decoder #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    pwm_duty_decoder_if.master      bus
);
    localparam int NW = CNT_W + 4;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {ARM, MEASURE, DIVIDE} state_t;

    logic sync1_q, sync1_d, sync2_q, sync2_d, pwm_d_q, pwm_d_d;
    logic pwm_s, rise;
    state_t state_q, state_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d, high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] period_inc, high_inc;
    logic [CNT_W-1:0] p_q, p_d, h_q, h_d;
    logic [NW-1:0]    rem_q, rem_d, trial;
    logic [3:0]       quo_q, quo_d, quo_next;
    logic [1:0]       step_q, step_d;
    logic [3:0]       duty_q, duty_d;
    logic [CNT_W-1:0] period_out_q, period_out_d, high_out_q, high_out_d;
    logic             valid_q, valid_d, stuck_q, stuck_d, overrun_q, overrun_d;

    // two-FF synchronizer plus the edge-detect delay, all frozen while disabled
    always_comb begin
        sync1_d = sync1_q;
        sync2_d = sync2_q;
        pwm_d_d = pwm_d_q;
        if (ena) begin
            sync1_d = bus.pwm_in;
            sync2_d = sync1_q;
            pwm_d_d = pwm_s;
        end
    end

`ifdef PWM_DEC_GLITCH_FILTER_EN
    logic sync3_q, sync3_d, filt_q, filt_d;

    // accept a new level only once three successive synchronized samples agree
    always_comb begin
        sync3_d = sync3_q;
        filt_d  = filt_q;
        if (ena) begin
            sync3_d = sync2_q;
            if ((sync1_q == sync2_q) && (sync2_q == sync3_q))
                filt_d = sync2_q;
        end
    end

    // filter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync3_q <= 1'b0;
            filt_q  <= 1'b0;
        end else begin
            sync3_q <= sync3_d;
            filt_q  <= filt_d;
        end
    end

    assign pwm_s = filt_q;
`else
    assign pwm_s = sync2_q;
`endif

    assign rise       = pwm_s & ~pwm_d_q;
    assign period_inc = (period_cnt_q == '1) ? period_cnt_q : period_cnt_q + 1'b1;
    assign high_inc   = (high_cnt_q == '1) ? high_cnt_q : high_cnt_q + 1'b1;

    // measurement FSM, restoring divider and result registers
    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        p_d          = p_q;
        h_d          = h_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        step_d       = step_q;
        duty_d       = duty_q;
        period_out_d = period_out_q;
        high_out_d   = high_out_q;
        valid_d      = 1'b0;
        stuck_d      = stuck_q;
        overrun_d    = overrun_q;
        trial        = NW'(p_q) << step_q;
        quo_next     = quo_q;
        if (ena) begin
            period_cnt_d = period_inc;
            if (pwm_s)
                high_cnt_d = high_inc;
            case (state_q)
                ARM: begin
                    if (rise) begin
                        period_cnt_d = CNT_W'(1);
                        high_cnt_d   = CNT_W'(1);
                        state_d      = MEASURE;
                    end else if ((period_cnt_q >= TIMEOUT_C) && !stuck_q) begin
                        duty_d       = pwm_s ? 4'd10 : 4'd0;
                        period_out_d = '0;
                        high_out_d   = '0;
                        stuck_d      = 1'b1;
                        valid_d      = 1'b1;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        p_d          = period_cnt_q;
                        h_d          = high_cnt_q;
                        rem_d        = (NW'(high_cnt_q) << 3) + (NW'(high_cnt_q) << 1)
                                     + NW'(period_cnt_q >> 1);
                        quo_d        = 4'd0;
                        step_d       = 2'd3;
                        period_cnt_d = CNT_W'(1);
                        high_cnt_d   = CNT_W'(1);
                        state_d      = DIVIDE;
                    end else if (period_cnt_q >= TIMEOUT_C) begin
                        duty_d       = pwm_s ? 4'd10 : 4'd0;
                        period_out_d = '0;
                        high_out_d   = '0;
                        stuck_d      = 1'b1;
                        valid_d      = 1'b1;
                        state_d      = ARM;
                    end
                end
                DIVIDE: begin
                    if (rem_q >= trial) begin
                        rem_d            = rem_q - trial;
                        quo_next[step_q] = 1'b1;
                    end
                    quo_d = quo_next;
                    if (step_q == 2'd0) begin
                        duty_d       = (quo_next > 4'd10) ? 4'd10 : quo_next;
                        period_out_d = p_q;
                        high_out_d   = h_q;
                        stuck_d      = 1'b0;
                        valid_d      = 1'b1;
                        state_d      = MEASURE;
                    end else begin
                        step_d = step_q - 2'd1;
                    end
                    // a period that ends while dividing is lost, but timing restarts
                    if (rise) begin
                        overrun_d    = 1'b1;
                        period_cnt_d = CNT_W'(1);
                        high_cnt_d   = CNT_W'(1);
                    end
                end
                default: state_d = ARM;
            endcase
        end
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            pwm_d_q      <= 1'b0;
            state_q      <= ARM;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            p_q          <= '0;
            h_q          <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            step_q       <= '0;
            duty_q       <= '0;
            period_out_q <= '0;
            high_out_q   <= '0;
            valid_q      <= 1'b0;
            stuck_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            pwm_d_q      <= pwm_d_d;
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            p_q          <= p_d;
            h_q          <= h_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            step_q       <= step_d;
            duty_q       <= duty_d;
            period_out_q <= period_out_d;
            high_out_q   <= high_out_d;
            valid_q      <= valid_d;
            stuck_q      <= stuck_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.duty_out   = duty_q;
    assign bus.duty_valid = valid_q & ena;
    assign bus.period_out = period_out_q;
    assign bus.high_out   = high_out_q;
    assign bus.stuck      = stuck_q;
    assign bus.overrun    = overrun_q;
endmodule
